fetch_stage: RTL

- Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the decode stage.
- Owns the program counter (PC_F), computes PC+4 and applies branch/jump redirects from execute.
- Presents the fetch address to the external instruction memory.
- Contains the IF/ID pipeline register feeding decode's instr_i, PC_F_i and PC_Plus4_F_i; supports stall (hold) and flush (NOP bubble) from the hazard unit.

---
 rtl/fetch_stage.sv | 84 ++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PC_F, applies execute-stage redirects and
// holds the IF/ID pipeline register with stall/flush control.
module fetch_stage #(
  parameter int unsigned                DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]      RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0]      NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF_i,
  input  logic                  StallD_i,
  input  logic                  FlushD_i,
  input  logic                  PCSrcE_i,
  input  logic [DATA_WIDTH-1:0] PCTargetE_i,
  input  logic [DATA_WIDTH-1:0] Instr_F_i,
  output logic [DATA_WIDTH-1:0] ImemAddr_o,
  output logic [DATA_WIDTH-1:0] PC_F_o,
  output logic [DATA_WIDTH-1:0] InstrD_o,
  output logic [DATA_WIDTH-1:0] PCD_o,
  output logic [DATA_WIDTH-1:0] PC_Plus4D_o,
  output logic                  ValidD_o
);

  logic [DATA_WIDTH-1:0] pc_f_q, pc_f_d;
  logic [DATA_WIDTH-1:0] pc_plus4_f;
  logic [DATA_WIDTH-1:0] instr_d_q, instr_d_d;
  logic [DATA_WIDTH-1:0] pc_d_q, pc_d_d;
  logic [DATA_WIDTH-1:0] pc_plus4_d_q, pc_plus4_d_d;
  logic                  valid_d_q, valid_d_d;

  // Redirect beats stall so a resolved branch is never dropped.
  always_comb begin
    pc_plus4_f = pc_f_q + DATA_WIDTH'(4);
    pc_f_d     = pc_f_q;
    if (PCSrcE_i) begin
      pc_f_d = {PCTargetE_i[DATA_WIDTH-1:2], 2'b00};
    end else if (!StallF_i) begin
      pc_f_d = pc_plus4_f;
    end
  end

  // Flush beats stall so a bubble always lands in decode.
  always_comb begin
    instr_d_d    = instr_d_q;
    pc_d_d       = pc_d_q;
    pc_plus4_d_d = pc_plus4_d_q;
    valid_d_d    = valid_d_q;
    if (FlushD_i) begin
      instr_d_d    = NOP_INSTR;
      pc_d_d       = '0;
      pc_plus4_d_d = '0;
      valid_d_d    = 1'b0;
    end else if (!StallD_i) begin
      instr_d_d    = Instr_F_i;
      pc_d_d       = pc_f_q;
      pc_plus4_d_d = pc_plus4_f;
      valid_d_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f_q       <= RESET_PC;
      instr_d_q    <= NOP_INSTR;
      pc_d_q       <= '0;
      pc_plus4_d_q <= '0;
      valid_d_q    <= 1'b0;
    end else begin
      pc_f_q       <= pc_f_d;
      instr_d_q    <= instr_d_d;
      pc_d_q       <= pc_d_d;
      pc_plus4_d_q <= pc_plus4_d_d;
      valid_d_q    <= valid_d_d;
    end
  end

  assign ImemAddr_o  = pc_f_q;
  assign PC_F_o      = pc_f_q;
  assign InstrD_o    = instr_d_q;
  assign PCD_o       = pc_d_q;
  assign PC_Plus4D_o = pc_plus4_d_q;
  assign ValidD_o    = valid_d_q;

endmodule
